// File: rtl/mem_copy_engine_if.sv
// Control and data-memory bus bundle for mem_copy_engine.
// MEM_COPY_CHECKSUM_EN adds the checksum signal.
interface mem_copy_engine_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] src_addr;
  logic [ADDR_WIDTH-1:0] dst_addr;
  logic [LEN_WIDTH-1:0]  length;
  logic                  busy;
  logic                  done;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic                  mem_write_en;
  logic                  mem_read_en;
  logic [DATA_WIDTH-1:0] mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] checksum;

  modport master (
    input  start, src_addr, dst_addr, length, mem_read_data,
    output busy, done, mem_address, mem_write_data, mem_write_en, mem_read_en, checksum
  );
  modport slave (
    output start, src_addr, dst_addr, length, mem_read_data,
    input  busy, done, mem_address, mem_write_data, mem_write_en, mem_read_en, checksum
  );
`else
  modport master (
    input  start, src_addr, dst_addr, length, mem_read_data,
    output busy, done, mem_address, mem_write_data, mem_write_en, mem_read_en
  );
  modport slave (
    output start, src_addr, dst_addr, length, mem_read_data,
    input  busy, done, mem_address, mem_write_data, mem_write_en, mem_read_en
  );
`endif
endinterface

// File: rtl/mem_copy_engine.sv
// Ascending block copy through a single-port byte memory, one byte per three clocks.
// Optional running checksum of written bytes when MEM_COPY_CHECKSUM_EN is defined.
module mem_copy_engine #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic                clk,
  input logic                rst,
  mem_copy_engine_if.master  bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RD_ADDR = 3'd1;
  localparam logic [2:0] RD_CAP  = 3'd2;
  localparam logic [2:0] WR      = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]            state;
  logic [ADDR_WIDTH-1:0] src;
  logic [ADDR_WIDTH-1:0] dst;
  logic [LEN_WIDTH-1:0]  remaining;

  // Outputs are set on the edge that enters each state, so every output is a flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      src                <= '0;
      dst                <= '0;
      remaining          <= '0;
      bus.busy           <= 1'b0;
      bus.done           <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_write_data <= '0;
      bus.mem_write_en   <= 1'b0;
      bus.mem_read_en    <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
      bus.checksum       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            src       <= bus.src_addr;
            dst       <= bus.dst_addr;
            remaining <= bus.length;
`ifdef MEM_COPY_CHECKSUM_EN
            bus.checksum <= '0;
`endif
            if (bus.length == '0) begin
              state    <= DONE;
              bus.done <= 1'b1;
            end else begin
              state           <= RD_ADDR;
              bus.busy        <= 1'b1;
              bus.mem_read_en <= 1'b1;
              bus.mem_address <= bus.src_addr;
            end
          end
        end
        RD_ADDR: begin
          // Source is latched by the memory on this edge; present dst next.
          state           <= RD_CAP;
          bus.mem_address <= dst;
        end
        RD_CAP: begin
          state              <= WR;
          bus.mem_read_en    <= 1'b0;
          bus.mem_write_en   <= 1'b1;
          bus.mem_write_data <= bus.mem_read_data;
        end
        WR: begin
          bus.mem_write_en <= 1'b0;
          src              <= src + 1'b1;
          dst              <= dst + 1'b1;
          remaining        <= remaining - 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
          bus.checksum     <= bus.checksum + bus.mem_write_data;
`endif
          if (remaining == LEN_WIDTH'(1)) begin
            state    <= DONE;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            state           <= RD_ADDR;
            bus.mem_read_en <= 1'b1;
            bus.mem_address <= src + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
        end
        default: begin
          state            <= IDLE;
          bus.busy         <= 1'b0;
          bus.done         <= 1'b0;
          bus.mem_write_en <= 1'b0;
          bus.mem_read_en  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine with a behavioural latched-address byte memory.
module tb_mem_copy_engine;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int LW = AW + 1;

  typedef struct {
    int        busy;
    int        reads;
    logic [7:0] sum;
  } done_t;

  logic clk;
  logic rst;
  mem_copy_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  mem_copy_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: latches the address when exactly one enable is high; a write lands at the old latch.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] lat;
  initial lat = '0;
  always @(posedge clk) begin
    if (bus.mem_write_en ^ bus.mem_read_en) begin
      if (bus.mem_write_en) mem[lat] <= bus.mem_write_data;
      lat <= bus.mem_address;
    end
  end
  assign bus.mem_read_data = bus.mem_read_en ? mem[lat] : '0;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int done_cnt  = 0;
  int both_cnt  = 0;
  int busy_cnt  = 0;
  int re_cnt    = 0;
  logic [AW+DW-1:0] exp_wr [$];
  done_t            exp_done [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic push_done(input int busy, input int reads, input logic [7:0] sum);
    done_t e;
    e.busy = busy; e.reads = reads; e.sum = sum;
    exp_done.push_back(e);
  endtask

  // Monitor: compares every write and every done pulse against the queued expectations.
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      re_cnt   = 0;
    end else begin
      logic [AW+DW-1:0] w;
      done_t e;
      if (bus.mem_read_en && bus.mem_write_en) both_cnt++;
      if (bus.busy) busy_cnt++;
      if (bus.mem_read_en) re_cnt++;
      if (bus.mem_write_en) begin
        if (exp_wr.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_write: got addr %0h data %0h, required no write", lat, bus.mem_write_data);
        end else begin
          w = exp_wr.pop_front();
          check("write_addr", 32'(lat), 32'(w[AW+DW-1:DW]));
          check("write_data", 32'(bus.mem_write_data), 32'(w[DW-1:0]));
        end
      end
      if (bus.done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          total_cnt++;
          $display("FAIL unexpected_done: got done, required none");
        end else begin
          e = exp_done.pop_front();
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
          check("read_cycles", 32'(re_cnt), 32'(e.reads));
          check("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
          check("checksum", 32'(bus.checksum), 32'(e.sum));
`endif
        end
        busy_cnt = 0;
        re_cnt   = 0;
      end
    end
  end

  task automatic start_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [LW-1:0] n);
    bus.start    = 1'b1;
    bus.src_addr = s;
    bus.dst_addr = d;
    bus.length   = n;
    @(posedge clk);
    #1;
    bus.start    = 1'b0;
    bus.src_addr = AW'($urandom);
    bus.dst_addr = AW'($urandom);
    bus.length   = LW'($urandom);
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check(name, 32'(done_cnt != d0), 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    bus.start = 1'b0; bus.src_addr = '0; bus.dst_addr = '0; bus.length = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    #1;
    mem[10'h010] <= 8'hA1; mem[10'h011] <= 8'hB2; mem[10'h012] <= 8'hC3; mem[10'h013] <= 8'hD4;
    mem[10'h3FE] <= 8'h11; mem[10'h3FF] <= 8'h22; mem[10'h000] <= 8'h33; mem[10'h001] <= 8'h44;
    mem[10'h020] <= 8'hFF; mem[10'h021] <= 8'h02; mem[10'h022] <= 8'h10;
    @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_enables", 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
    check("rst_addr", 32'(bus.mem_address), 32'd0);
    check("rst_wdata", 32'(bus.mem_write_data), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Basic 4-byte copy
    push_wr(10'h200, 8'hA1); push_wr(10'h201, 8'hB2); push_wr(10'h202, 8'hC3); push_wr(10'h203, 8'hD4);
    push_done(12, 8, 8'hEA);
    start_copy(10'h010, 10'h200, 11'd4);
    wait_done("done_basic", 40);

    // Source wraps past the top of memory
    push_wr(10'h100, 8'h11); push_wr(10'h101, 8'h22); push_wr(10'h102, 8'h33); push_wr(10'h103, 8'h44);
    push_done(12, 8, 8'hAA);
    start_copy(10'h3FE, 10'h100, 11'd4);
    wait_done("done_wrap", 40);

    // Zero length: done on the next cycle, no access
    push_done(0, 0, 8'h00);
    start_copy(10'h010, 10'h300, 11'd0);
    @(negedge clk);
    check("len0_done_next", 32'(bus.done), 32'd1);
    wait_done("done_len0", 10);

    // Restart while busy is ignored
    push_wr(10'h280, 8'hA1); push_wr(10'h281, 8'hB2); push_wr(10'h282, 8'hC3);
    push_done(9, 6, 8'h16);
    d0 = done_cnt;
    start_copy(10'h010, 10'h280, 11'd3);
    repeat (3) @(posedge clk);
    #1;
    start_copy(10'h3FE, 10'h000, 11'd5);
    wait_done("done_restart", 40);
    repeat (10) @(posedge clk);
    #1;
    check("restart_single_done", 32'(done_cnt - d0), 32'd1);

    // Checksum wraps modulo 256
    push_wr(10'h300, 8'hFF); push_wr(10'h301, 8'h02); push_wr(10'h302, 8'h10);
    push_done(9, 6, 8'h11);
    start_copy(10'h020, 10'h300, 11'd3);
    wait_done("done_checksum", 40);

    // Reset during cycle 7 of a 4-byte copy: two bytes land, nothing after
    push_wr(10'h380, 8'h11); push_wr(10'h381, 8'h22);
    d0 = done_cnt;
    start_copy(10'h3FE, 10'h380, 11'd4);
    repeat (6) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_enables", 32'({bus.mem_read_en, bus.mem_write_en}), 32'd0);
    check("abort_addr", 32'(bus.mem_address), 32'd0);
    check("abort_wdata", 32'(bus.mem_write_data), 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);

    check("mem_200", 32'(mem[10'h200]), 32'hA1);
    check("mem_203", 32'(mem[10'h203]), 32'hD4);
    check("mem_103", 32'(mem[10'h103]), 32'h44);
    check("mem_282", 32'(mem[10'h282]), 32'hC3);
    check("mem_302", 32'(mem[10'h302]), 32'h10);
    check("mem_381", 32'(mem[10'h381]), 32'h22);
    check("mem_382_untouched", 32'(mem[10'h382]), 32'h00);
    check("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);
    check("never_both_enables", 32'(both_cnt), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end
endmodule
